pzc_output_scaler: RTL and testbench

- Pipelined, parametrised replacement for the combinational pole-zero-cancellation (PZC) output scaling in the simulator top level. Today that scaling divides by a constant M factor, arithmetic-shifts right and truncates to the GPIO width.
- Adds:
  - a runtime-loadable divisor;
  - full-rate pipelined division;
  - saturation to the output width, with a sticky counter;
  - valid tracking.
- Sits between the PZC output of the simulator core and the GPIO/DAC pins, clocked from the 40 MHz PLL.

---
 rtl/pzc_output_scaler.sv | 183 ++++++++++++++++++
 tb/tb_pzc_output_scaler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzc_output_scaler.sv
// pzc_output_scaler: pipelined PZC output scaling.
// Each sample is divided by a runtime-loadable divisor using a restoring divider
// that produces one quotient bit per stage. The quotient is then arithmetic-shifted
// right and saturated to the output width. Saturation events are counted.
// Optional build macro PZC_ROUND_EN: when defined, the division rounds half away
// from zero instead of truncating.
`timescale 1ns/1ps
module pzc_output_scaler #(
   parameter int IN_W      = 46,
   parameter int DIV_W     = 16,
   parameter int SHIFT     = 10,
   parameter int OUT_W     = 13,
   parameter int DEFAULT_M = 454
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [IN_W-1:0]    in_data,
   input  logic               m_load,
   input  logic [DIV_W-1:0]   m_value,
   output logic               out_valid,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_sat,
   output logic [15:0]        sat_count,
   input  logic               sat_clr,
   output logic               m_err
);

   localparam logic signed [IN_W:0] R_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] R_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [DIV_W-1:0]        m_reg;
   logic [IN_W-1:0]         abs_in;
   logic [IN_W-1:0]         dividend;

   // Per-stage divider state: dividend/quotient shift register, partial remainder,
   // divisor carried with the sample, sign and valid.
   logic [IN_W-1:0]         dq     [0:IN_W];
   logic [DIV_W-1:0]        rm     [0:IN_W-1];
   logic [DIV_W-1:0]        dv     [0:IN_W-1];
   logic                    sg     [0:IN_W];
   logic                    vl     [0:IN_W];
   logic [IN_W-1:0]         nxt_dq [1:IN_W];
   logic [DIV_W-1:0]        nxt_rm [1:IN_W-1];

   logic signed [IN_W:0]    signed_q;
   logic signed [IN_W:0]    shifted;
   logic signed [IN_W:0]    r_reg;
   logic                    r_valid;
   logic [OUT_W-1:0]        sat_data;
   logic                    sat_flag;

   // The trial value {rem, msb} is DIV_W+1 bits wide; if its top bit is set it
   // already exceeds any divisor, so only the low DIV_W bits need comparing.
   function automatic logic stage_ge(input logic [DIV_W-1:0] rem, input logic msb,
                                     input logic [DIV_W-1:0] d);
      logic [DIV_W-1:0] low;
      low = {rem[DIV_W-2:0], msb};
      return rem[DIV_W-1] || (low >= d);
   endfunction

   // The restored remainder is always below the divisor, so DIV_W bits suffice
   // and the subtraction may wrap through the dropped top bit.
   function automatic logic [DIV_W-1:0] stage_rem(input logic [DIV_W-1:0] rem, input logic msb,
                                                  input logic [DIV_W-1:0] d);
      logic [DIV_W-1:0] low;
      low = {rem[DIV_W-2:0], msb};
      return stage_ge(rem, msb, d) ? (low - d) : low;
   endfunction

   // Magnitude of the incoming sample, optionally pre-biased by half the divisor for rounding.
   always_comb begin
      abs_in = in_data[IN_W-1] ? -in_data : in_data;
`ifdef PZC_ROUND_EN
      dividend = abs_in + {{(IN_W-DIV_W+1){1'b0}}, m_reg[DIV_W-1:1]};
`else
      dividend = abs_in;
`endif
   end

   // One restoring-division step per stage: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      for (int k = 1; k <= IN_W; k++) begin
         nxt_dq[k] = {dq[k-1][IN_W-2:0], stage_ge(rm[k-1], dq[k-1][IN_W-1], dv[k-1])};
      end
      for (int k = 1; k < IN_W; k++) begin
         nxt_rm[k] = stage_rem(rm[k-1], dq[k-1][IN_W-1], dv[k-1]);
      end
   end

   // Re-apply the sign to the quotient, then floor-shift.
   always_comb begin
      signed_q = sg[IN_W] ? -$signed({1'b0, dq[IN_W]}) : $signed({1'b0, dq[IN_W]});
      shifted  = signed_q >>> SHIFT;
   end

   // Clip the shifted value into the signed output range.
   always_comb begin
      sat_flag = 1'b0;
      sat_data = r_reg[OUT_W-1:0];
      if (r_reg > R_MAX) begin
         sat_flag = 1'b1;
         sat_data = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (r_reg < R_MIN) begin
         sat_flag = 1'b1;
         sat_data = {1'b1, {(OUT_W-1){1'b0}}};
      end
   end

   // Data path registers; contents are qualified by the valid pipeline, so no reset is needed.
   always_ff @(posedge clk) begin
      dq[0] <= dividend;
      rm[0] <= '0;
      dv[0] <= m_reg;
      sg[0] <= in_data[IN_W-1];
      for (int k = 1; k <= IN_W; k++) begin
         dq[k] <= nxt_dq[k];
         sg[k] <= sg[k-1];
      end
      for (int k = 1; k < IN_W; k++) begin
         rm[k] <= nxt_rm[k];
         dv[k] <= dv[k-1];
      end
      r_reg <= shifted;
   end

   // Valid bits travelling alongside each sample; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k <= IN_W; k++) begin
            vl[k] <= 1'b0;
         end
         r_valid <= 1'b0;
      end else begin
         vl[0] <= in_valid;
         for (int k = 1; k <= IN_W; k++) begin
            vl[k] <= vl[k-1];
         end
         r_valid <= vl[IN_W];
      end
   end

   // Output register: data and saturation flag hold their last values between valid samples.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= r_valid;
         if (r_valid) begin
            out_data <= sat_data;
            out_sat  <= sat_flag;
         end
      end
   end

   // Count clipped samples as they are presented; a clear in the same cycle as an event leaves 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_count <= (out_valid && out_sat) ? 16'd1 : 16'd0;
      end else if (out_valid && out_sat && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

   // Divisor register: zero loads are rejected and flagged until the next reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_reg <= DIV_W'(DEFAULT_M);
         m_err <= 1'b0;
      end else if (m_load) begin
         if (m_value != '0) begin
            m_reg <= m_value;
         end else begin
            m_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pzc_output_scaler.sv
// Testbench for pzc_output_scaler.
// Expected results are produced by a plain-arithmetic reference model and queued
// when each sample is driven; a negedge monitor pops and compares them as
// out_valid appears. A second instance with SHIFT=0 exercises rounding.
`timescale 1ns/1ps
module tb_pzc_output_scaler;

   localparam int IN_W      = 46;
   localparam int DIV_W     = 16;
   localparam int SHIFT     = 10;
   localparam int OUT_W     = 13;
   localparam int DEFAULT_M = 454;
   localparam int LAT       = IN_W + 3;
   localparam longint OMAX  = (64'sd1 <<< (OUT_W-1)) - 1;
   localparam longint OMIN  = -(64'sd1 <<< (OUT_W-1));

   typedef struct {
      longint data;
      bit     sat;
      int     cyc;
   } exp_t;

   logic                    clk;
   logic                    rst;
   logic                    in_valid;
   logic [IN_W-1:0]         in_data;
   logic                    m_load;
   logic [DIV_W-1:0]        m_value;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;
   logic [15:0]             sat_count;
   logic                    sat_clr;
   logic                    m_err;

   logic                    r_in_valid;
   logic [IN_W-1:0]         r_in_data;
   logic                    r_m_load;
   logic [DIV_W-1:0]        r_m_value;
   logic                    r_sat_clr;
   logic                    r_out_valid;
   logic signed [OUT_W-1:0] r_out_data;
   logic                    r_out_sat;
   logic [15:0]             r_sat_count;
   logic                    r_m_err;

   exp_t   sb[$];
   exp_t   mon_e;
   int     checks     = 0;
   int     failures   = 0;
   int     cyc        = 0;
   bit     mon_en     = 0;
   longint model_m    = DEFAULT_M;
   bit     model_merr = 0;
   int     model_cnt  = 0;
   longint last_data  = 0;
   bit     last_sat   = 0;
   bit     mon_ev;

   pzc_output_scaler dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .m_load(m_load), .m_value(m_value), .out_valid(out_valid), .out_data(out_data),
      .out_sat(out_sat), .sat_count(sat_count), .sat_clr(sat_clr), .m_err(m_err)
   );

   pzc_output_scaler #(.SHIFT(0)) dut_round (
      .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_data(r_in_data),
      .m_load(r_m_load), .m_value(r_m_value), .out_valid(r_out_valid), .out_data(r_out_data),
      .out_sat(r_out_sat), .sat_count(r_sat_count), .sat_clr(r_sat_clr), .m_err(r_m_err)
   );

   initial clk = 1'b0;
   always #12.5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: signed division (truncating or rounding half away from zero), then floor shift.
   function automatic longint ref_div(input longint x, input longint m, input int sh);
      longint ax;
      longint q;
      ax = (x < 0) ? -x : x;
`ifdef PZC_ROUND_EN
      q = (ax + m / 2) / m;
`else
      q = ax / m;
`endif
      if (x < 0) q = -q;
      return q >>> sh;
   endfunction

   function automatic longint clip(input longint r);
      if (r > OMAX) return OMAX;
      if (r < OMIN) return OMIN;
      return r;
   endfunction

   task automatic applyStimulus(input bit v, input longint x, input bit ld, input longint mv, input bit clr);
      exp_t   e;
      longint r;
      @(posedge clk);
      #1;
      in_valid = v;
      in_data  = x[IN_W-1:0];
      m_load   = ld;
      m_value  = mv[DIV_W-1:0];
      sat_clr  = clr;
      if (v) begin
         r      = ref_div(x, model_m, SHIFT);
         e.data = clip(r);
         e.sat  = (r > OMAX) || (r < OMIN);
         e.cyc  = cyc + LAT;
         sb.push_back(e);
      end
      if (ld) begin
         if (mv != 0) model_m = mv;
         else model_merr = 1;
      end
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      rst        = 1'b0;
      in_valid   = 1'b0;
      m_load     = 1'b0;
      sat_clr    = 1'b0;
      model_m    = DEFAULT_M;
      model_merr = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < LAT + 20 && sb.size() != 0; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
      end
      checkOutput("scoreboard_drained", sb.size(), 0);
   endtask

   function automatic longint rand_sample();
      longint v;
      v = {$urandom(), $urandom()};
      return v >>> $urandom_range(18, 50);
   endfunction

   // Monitor: compare every presented output, hold behaviour, and the saturation counter.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_ev = 0;
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_out_valid", out_valid, 0);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("out_data", out_data, mon_e.data);
               checkOutput("out_sat", out_sat, mon_e.sat);
               checkOutput("latency_cycle", cyc, mon_e.cyc);
               mon_ev    = mon_e.sat;
               last_data = mon_e.data;
               last_sat  = mon_e.sat;
            end
         end else begin
            checkOutput("hold_out_data", out_data, last_data);
            checkOutput("hold_out_sat", out_sat, last_sat);
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
               checkOutput("missing_out_valid", out_valid, 1);
               mon_e = sb.pop_front();
            end
         end
         checkOutput("sat_count", sat_count, model_cnt);
         if (!rst) begin
            sb.delete();
            model_cnt = 0;
            last_data = 0;
            last_sat  = 0;
         end else if (sat_clr) begin
            model_cnt = mon_ev ? 1 : 0;
         end else if (mon_ev && model_cnt < 65535) begin
            model_cnt++;
         end
      end
   end

   initial begin
      #250000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint sat_big;
      int     t0;
      int     got;
      sat_big    = 64'sd454 * 64'sd1024 * 64'sd5000;
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      m_load     = 1'b0;
      m_value    = '0;
      sat_clr    = 1'b0;
      r_in_valid = 1'b0;
      r_in_data  = '0;
      r_m_load   = 1'b0;
      r_m_value  = '0;
      r_sat_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_out_sat", out_sat, 0);
      checkOutput("reset_sat_count", sat_count, 0);
      checkOutput("reset_m_err", m_err, 0);
      checkOutput("reset_round_out_valid", r_out_valid, 0);
      mon_en = 1;

      // Nominal scaling and floor-shift boundaries
      applyStimulus(1, 64'sd2324480, 0, 0, 0);
      applyStimulus(1, -64'sd2324480, 0, 0, 0);
      applyStimulus(1, -64'sd454, 0, 0, 0);
      applyStimulus(1, -64'sd453, 0, 0, 0);
      applyStimulus(1, 64'sd453, 0, 0, 0);
      drain();

      // Saturation in both directions
      applyStimulus(1, sat_big, 0, 0, 0);
      applyStimulus(1, -sat_big, 0, 0, 0);
      drain();
      checkOutput("sat_count_two", sat_count, 2);

      // Clear coinciding with a third saturated output
      applyStimulus(1, sat_big, 0, 0, 0);
      t0 = cyc;
      while (cyc < t0 + LAT - 1) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("sat_count_clr_with_event", sat_count, 1);
      applyStimulus(1, -(64'sd1 <<< (IN_W-1)), 0, 0, 0);
      drain();
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("sat_count_clr_alone", sat_count, 0);

      // Divisor load timing and rejected zero load
      applyStimulus(1, 64'sd3072000, 1, 1000, 0);
      applyStimulus(1, 64'sd3072000, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 64'sd5120000, 0, 0, 0);
      drain();
      checkOutput("m_err_after_zero_load", m_err, model_merr);
      applyStimulus(0, 0, 1, DEFAULT_M, 0);

      // Back-to-back random stream with occasional divisor loads
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1, rand_sample(), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2000), 0);
      end
      drain();
      checkOutput("m_err_stream", m_err, model_merr);

      // Random stream interrupted by a one-cycle reset
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            applyReset();
            checkOutput("sat_count_after_reset", sat_count, 0);
            checkOutput("m_err_after_reset", m_err, 0);
         end
         applyStimulus(1, rand_sample(), (i < 50) && ($urandom_range(0, 9) == 0),
                       $urandom_range(0, 2000), 0);
      end
      drain();
      checkOutput("m_err_stream_reset", m_err, model_merr);

      // Rounding behaviour on the SHIFT=0 instance
      @(posedge clk);
      #1;
      r_in_valid = 1'b1;
      r_in_data  = 46'sd681;
      @(posedge clk);
      #1;
      r_in_data  = -46'sd681;
      @(posedge clk);
      #1;
      r_in_valid = 1'b0;
      r_in_data  = '0;
      got = 0;
      for (int i = 0; i < LAT + 10 && got < 2; i++) begin
         @(negedge clk);
         if (r_out_valid === 1'b1) begin
            if (got == 0) checkOutput("round_pos", r_out_data, ref_div(681, DEFAULT_M, 0));
            else checkOutput("round_neg", r_out_data, ref_div(-681, DEFAULT_M, 0));
            checkOutput("round_sat", r_out_sat, 0);
            got++;
         end
      end
      checkOutput("round_outputs_seen", got, 2);
      checkOutput("round_sat_count", r_sat_count, 0);
      checkOutput("round_m_err", r_m_err, 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
